// File: rtl/pipeline_stage_buffer.sv
// Pipeline boundary register with valid/ready handshake, flush and an
// optional two-entry skid buffer. The control bundle is gated by out_valid
// so that a bubble can never assert a write enable downstream.
module pipeline_stage_buffer #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Main register drives the outputs; skid register holds one overflow entry.
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;
  logic [1:0]        occupancy_q,  occupancy_d;

  logic accept;
  logic retire;

  // Handshake qualifiers for the coming edge.
  always_comb begin
    accept = in_valid && in_ready;
    retire = main_valid_q && out_ready;
  end

  // Next-state logic: reset beats flush, flush beats accept/retire.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (reset) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_data_d  = '0;
    end else if (flush) begin
      // Data registers keep their contents; only validity is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (skid_valid_q) begin
        // Full: in_ready is low, so only a retire can change anything.
        if (retire) begin
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end
      end else if (!main_valid_q) begin
        if (accept) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = in_ctrl;
          main_data_d  = in_data;
        end
      end else if (retire && accept) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (retire) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        // Downstream stalled while we still advertised ready: park it.
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end else begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else if (retire) begin
        main_valid_d = 1'b0;
      end
    end

    occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    // Registered ready: room exists exactly when the skid slot is free.
    in_ready_d  = !skid_valid_d;
  end

  // State registers.
  always_ff @(posedge clk) begin
    main_valid_q <= main_valid_d;
    main_ctrl_q  <= main_ctrl_d;
    main_data_q  <= main_data_d;
    skid_valid_q <= skid_valid_d;
    skid_ctrl_q  <= skid_ctrl_d;
    skid_data_q  <= skid_data_d;
    in_ready_q   <= in_ready_d;
    occupancy_q  <= occupancy_d;
  end

  // Ready path: registered with a skid slot, combinational without one.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = in_ready_q & ~reset;
    end else begin : g_comb_ready
      assign in_ready = (~main_valid_q | out_ready) & ~reset;
    end
  endgenerate

  // Control bits forced to zero on a bubble.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
      assign out_ctrl[gi] = main_ctrl_q[gi] & main_valid_q;
    end
  endgenerate

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Self-checking bench: a SKID=1 and a SKID=0 instance share one stimulus
// stream; each is compared every cycle against its own FIFO-queue model.
module tb_pipeline_stage_buffer;

  localparam int DW = 32;
  localparam int CW = 3;
  localparam int EW = CW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          s1_in_ready, s1_out_valid;
  logic [CW-1:0] s1_out_ctrl;
  logic [DW-1:0] s1_out_data;
  logic [1:0]    s1_occ;
  logic          s0_in_ready, s0_out_valid;
  logic [CW-1:0] s0_out_ctrl;
  logic [DW-1:0] s0_out_data;
  logic [1:0]    s0_occ;

  pipeline_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s1_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s1_out_valid), .out_ready(out_ready), .out_ctrl(s1_out_ctrl),
    .out_data(s1_out_data), .occupancy(s1_occ)
  );

  pipeline_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s0_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s0_out_valid), .out_ready(out_ready), .out_ctrl(s0_out_ctrl),
    .out_data(s0_out_data), .occupancy(s0_occ)
  );

  int errors = 0;
  int checks = 0;

  // Reference models: ordered queues of {ctrl, data}, capacity 2 and 1.
  logic [EW-1:0] q1[$];
  logic [EW-1:0] q0[$];
  logic [DW-1:0] held1 = '0, held0 = '0;
  bit            def1 = 1'b0, def0 = 1'b0;
  bit            armed = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input bit skid, input int sz);
    if (reset) return 1'b0;
    if (skid) return (sz < 2);
    return (sz == 0) || out_ready;
  endfunction

  task automatic check_one(input string nm, input bit skid, input int sz,
                           input logic [EW-1:0] head, input logic [DW-1:0] held,
                           input bit held_def, input logic rdy, input logic vld,
                           input logic [CW-1:0] ctl, input logic [DW-1:0] dat,
                           input logic [1:0] occ);
    logic [CW-1:0] exp_ctl;
    exp_ctl = (sz > 0) ? head[EW-1:DW] : '0;
    chk({nm, ".in_ready"},  64'(rdy), 64'(exp_ready(skid, sz)));
    chk({nm, ".out_valid"}, 64'(vld), 64'(sz > 0));
    chk({nm, ".occupancy"}, 64'(occ), 64'(sz));
    chk({nm, ".out_ctrl"},  64'(ctl), 64'(exp_ctl));
    if (sz > 0) chk({nm, ".out_data"}, 64'(dat), 64'(head[DW-1:0]));
    else if (held_def) chk({nm, ".out_data_held"}, 64'(dat), 64'(held));
  endtask

  // One clock cycle: drive at negedge, check pre-edge outputs, advance models.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    logic rdy1, rdy0, ret, acc;
    @(negedge clk);
    reset = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
    #1;
    if (armed) begin
      check_one("skid1", 1'b1, q1.size(), (q1.size() > 0) ? q1[0] : '0, held1, def1,
                s1_in_ready, s1_out_valid, s1_out_ctrl, s1_out_data, s1_occ);
      check_one("skid0", 1'b0, q0.size(), (q0.size() > 0) ? q0[0] : '0, held0, def0,
                s0_in_ready, s0_out_valid, s0_out_ctrl, s0_out_data, s0_occ);
    end
    rdy1 = exp_ready(1'b1, q1.size());
    rdy0 = exp_ready(1'b0, q0.size());
    if (q1.size() > 0) held1 = q1[0][DW-1:0];
    if (q0.size() > 0) held0 = q0[0][DW-1:0];
    @(posedge clk);
    if (r) begin
      q1.delete(); q0.delete(); held1 = '0; held0 = '0; def1 = 1'b1; def0 = 1'b1;
      armed = 1'b1;
    end else if (f) begin
      q1.delete(); q0.delete(); def1 = 1'b1; def0 = 1'b1;
    end else begin
      ret = (q1.size() > 0) && ordy;
      acc = iv && rdy1;
      if (ret) void'(q1.pop_front());
      if (acc) begin q1.push_back({c, d}); def1 = 1'b0; end
      ret = (q0.size() > 0) && ordy;
      acc = iv && rdy0;
      if (ret) void'(q0.pop_front());
      if (acc) begin q0.push_back({c, d}); def0 = 1'b0; end
    end
  endtask

  initial begin
    // Reset held two cycles with a valid offer pending.
    step(1, 0, 1, 3'b111, 32'hDEAD_BEEF, 0);
    step(1, 0, 1, 3'b111, 32'hDEAD_BEEF, 0);
    step(0, 0, 0, 3'b000, 32'h0, 0);

    // Streaming at full rate.
    step(0, 0, 1, 3'b001, 32'h10, 1);
    step(0, 0, 1, 3'b001, 32'h11, 1);
    step(0, 0, 1, 3'b001, 32'h12, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);

    // Backpressure fills both entries; third offer must wait.
    step(0, 0, 1, 3'b010, 32'hA0, 0);
    step(0, 0, 1, 3'b010, 32'hA1, 0);
    step(0, 0, 1, 3'b010, 32'hA2, 0);
    step(0, 0, 1, 3'b010, 32'hA2, 0);
    step(0, 0, 1, 3'b010, 32'hA2, 1);
    step(0, 0, 1, 3'b010, 32'hA2, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);

    // Flush while full, with an input offered in the flush cycle.
    step(0, 0, 1, 3'b011, 32'hB0, 0);
    step(0, 0, 1, 3'b011, 32'hB1, 0);
    step(0, 1, 1, 3'b011, 32'hB2, 0);
    step(0, 0, 0, 3'b000, 32'h0, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);

    // Bubbles carrying nonzero ctrl, then a real entry.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 3'b101, 32'h55, 1);
    step(0, 0, 1, 3'b101, 32'h56, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);

    // Combinational ready release on the single-register instance.
    step(0, 0, 1, 3'b100, 32'hC0, 0);
    step(0, 0, 1, 3'b100, 32'hC1, 0);
    step(0, 0, 1, 3'b100, 32'hC1, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);
    step(0, 0, 0, 3'b000, 32'h0, 1);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), 3'($urandom), $urandom,
           ($urandom_range(0, 2) != 0));
    end
    step(0, 0, 0, 3'b000, 32'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
